// File: rtl/mmio_io_if.sv
// mmio_io_if -- processor data-bus bundle shared by the CPU and the
// memory-mapped I/O block.
//
// Signals:
//   realaddr : processor word address (master -> slave)
//   dout     : processor write data   (master -> slave)
//   W        : processor write strobe (master -> slave)
//   rdata    : registered read data   (slave -> master)
//   hit      : rdata is valid for the previous cycle's address (slave -> master)
//
// Modports:
//   master : the processor side (drives address, data and strobe)
//   slave  : the peripheral side (returns read data and hit)

interface mmio_io_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic [ADDR_W-1:0] realaddr;
   logic [DATA_W-1:0] dout;
   logic              W;
   logic [DATA_W-1:0] rdata;
   logic              hit;

   modport master (
      output realaddr,
      output dout,
      output W,
      input  rdata,
      input  hit
   );

   modport slave (
      input  realaddr,
      input  dout,
      input  W,
      output rdata,
      output hit
   );

endinterface

// File: rtl/mmio_io.sv
// mmio_io -- memory-mapped I/O peripheral that sits on the processor data bus
// next to the on-chip RAM. Provides a bank of output registers, synchronised
// switch and key inputs, sticky key-press capture and a maskable interrupt.
// The top level selects rdata onto the processor din whenever hit is high.
//
// Register map (word offsets from BASE_ADDR, N = NUM_OUT):
//   0..N-1 OUT[i] RW    N   SW  RO    N+1 KEY RO (1 = pressed)
//   N+2    EDGE   RW1C  N+3 MASK RW
//
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   reset  : synchronous, active-high reset
//   bus    : processor bus (slave modport): realaddr, dout, W in; rdata, hit out
//   out_q  : output registers, register i at [i*OUT_W +: OUT_W]
//   sw_in  : asynchronous switch levels
//   key_in : asynchronous keys, active-low (0 = pressed)
//   irq    : registered interrupt request, |(EDGE & MASK)

module mmio_io #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_000F,
   parameter int unsigned       NUM_OUT     = 1,
   parameter int unsigned       OUT_W       = 10,
   parameter int unsigned       IN_W        = 10,
   parameter int unsigned       KEY_W       = 4,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   mmio_io_if.slave                 bus,
   output logic [NUM_OUT*OUT_W-1:0] out_q,
   input  logic [IN_W-1:0]          sw_in,
   input  logic [KEY_W-1:0]         key_in,
   output logic                     irq
);

   localparam int unsigned       SPAN     = NUM_OUT + 4;
   localparam logic [ADDR_W-1:0] OFF_SW   = ADDR_W'(NUM_OUT);
   localparam logic [ADDR_W-1:0] OFF_KEY  = ADDR_W'(NUM_OUT + 1);
   localparam logic [ADDR_W-1:0] OFF_EDGE = ADDR_W'(NUM_OUT + 2);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NUM_OUT + 3);

   logic [ADDR_W-1:0] offset;
   logic              in_range;
   logic              wr;

   logic [IN_W-1:0]   sw_sync  [SYNC_STAGES];
   logic [KEY_W-1:0]  key_sync [SYNC_STAGES];
   logic [KEY_W-1:0]  key_dly;
   logic [KEY_W-1:0]  key_now;
   logic [KEY_W-1:0]  key_prev;
   logic [KEY_W-1:0]  press;

   logic [OUT_W-1:0]  out_reg [NUM_OUT];
   logic [KEY_W-1:0]  edge_q;
   logic [KEY_W-1:0]  mask_q;
   logic [KEY_W-1:0]  edge_clr;

   logic [DATA_W-1:0] rd_val;
   logic              unused_dout_bits;

   // Only the low field of each register is stored; the rest of dout is
   // intentionally dropped.
   assign unused_dout_bits = ^bus.dout;

   // Address decode. The lower-bound test guards against the subtraction
   // wrapping round for addresses below the base.
   always_comb begin
      offset   = bus.realaddr - BASE_ADDR;
      in_range = (bus.realaddr >= BASE_ADDR) && (offset < ADDR_W'(SPAN));
      wr       = bus.W && in_range;
   end

   // Input synchronisers. Key chains reset to 1 (released) so the edge
   // detector cannot see a press as the chain fills after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sw_sync[i]  <= '0;
            key_sync[i] <= '1;
         end
         key_dly <= '1;
      end else begin
         sw_sync[0]  <= sw_in;
         key_sync[0] <= key_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync[i]  <= sw_sync[i-1];
            key_sync[i] <= key_sync[i-1];
         end
         key_dly <= key_sync[SYNC_STAGES-1];
      end
   end

   // Keys are active-low on the pins; internally 1 means pressed. A press is
   // a 0->1 change of the pressed level between the delay flop and the
   // final synchroniser stage, so a held key only fires once.
   always_comb begin
      key_now  = ~key_sync[SYNC_STAGES-1];
      key_prev = ~key_dly;
      press    = key_now & ~key_prev;
   end

   // Output register bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            out_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (wr && (offset == ADDR_W'(i))) begin
               out_reg[i] <= bus.dout[OUT_W-1:0];
            end
         end
      end
   end

   always_comb begin
      out_q = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         out_q[i*OUT_W +: OUT_W] = out_reg[i];
      end
   end

   // Write-1-to-clear mask for EDGE; zero when EDGE is not being written.
   always_comb begin
      edge_clr = '0;
      if (wr && (offset == OFF_EDGE)) begin
         edge_clr = bus.dout[KEY_W-1:0];
      end
   end

   // EDGE and MASK. The press term is OR-ed in after the clear so a press
   // arriving together with a clear of the same bit leaves it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_q <= '0;
         mask_q <= '0;
      end else begin
         edge_q <= (edge_q & ~edge_clr) | press;
         if (wr && (offset == OFF_MASK)) begin
            mask_q <= bus.dout[KEY_W-1:0];
         end
      end
   end

   // Read multiplexer; it reflects register contents before this cycle's
   // write, so a same-cycle read returns the old value.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (offset == ADDR_W'(i)) begin
            rd_val[OUT_W-1:0] = out_reg[i];
         end
      end
      if (offset == OFF_SW) begin
         rd_val[IN_W-1:0] = sw_sync[SYNC_STAGES-1];
      end
      if (offset == OFF_KEY) begin
         rd_val[KEY_W-1:0] = key_now;
      end
      if (offset == OFF_EDGE) begin
         rd_val[KEY_W-1:0] = edge_q;
      end
      if (offset == OFF_MASK) begin
         rd_val[KEY_W-1:0] = mask_q;
      end
   end

   // Registered read port and interrupt, giving the same one-cycle latency
   // as the synchronous RAM alongside.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rdata <= '0;
         bus.hit   <= 1'b0;
         irq       <= 1'b0;
      end else begin
         bus.rdata <= in_range ? rd_val : '0;
         bus.hit   <= in_range;
         irq       <= |(edge_q & mask_q);
      end
   end

endmodule

// File: tb/tb_mmio_io.sv
// tb_mmio_io -- self-checking bench for mmio_io. A two-register instance is
// checked against a behavioural model (input histories, register arrays);
// a one-register instance covers the single LED latch case.

module tb_mmio_io;

   localparam int          N     = 2;
   localparam int          OUT_W = 10;
   localparam int          IN_W  = 10;
   localparam int          KEY_W = 4;
   localparam int          S     = 2;
   localparam logic [31:0] BASE  = 32'h0000_000F;
   localparam logic [31:0] A_SW   = BASE + N;
   localparam logic [31:0] A_KEY  = BASE + N + 1;
   localparam logic [31:0] A_EDGE = BASE + N + 2;
   localparam logic [31:0] A_MASK = BASE + N + 3;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [IN_W-1:0]      sw_in = '0;
   logic [KEY_W-1:0]     key_in = '1;
   logic [N*OUT_W-1:0]   out_q;
   logic                 irq;
   logic [OUT_W-1:0]     out_q1;
   logic                 irq1;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   logic [OUT_W-1:0] m_out [N];
   logic [KEY_W-1:0] m_edge, m_mask;
   logic             m_irq, m_hit;
   logic [31:0]      m_rdata;
   logic [KEY_W-1:0] klog [S+1];
   logic [IN_W-1:0]  slog [S+1];

   mmio_io_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mmio_io_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   mmio_io #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .NUM_OUT(N),
             .OUT_W(OUT_W), .IN_W(IN_W), .KEY_W(KEY_W), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset(reset), .bus(bus), .out_q(out_q),
      .sw_in(sw_in), .key_in(key_in), .irq(irq));

   mmio_io #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .NUM_OUT(1),
             .OUT_W(OUT_W), .IN_W(IN_W), .KEY_W(KEY_W), .SYNC_STAGES(S)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .out_q(out_q1),
      .sw_in(sw_in), .key_in(key_in), .irq(irq1));

   always #5 clk = ~clk;

   function automatic logic [31:0] model_read(input int off);
      logic [31:0] v;
      v = '0;
      if (off < N) v[OUT_W-1:0] = m_out[off];
      else if (off == N) v[IN_W-1:0] = slog[S-1];
      else if (off == N + 1) v[KEY_W-1:0] = ~klog[S-1];
      else if (off == N + 2) v[KEY_W-1:0] = m_edge;
      else if (off == N + 3) v[KEY_W-1:0] = m_mask;
      return v;
   endfunction

   function automatic logic [N*OUT_W-1:0] model_out_q();
      logic [N*OUT_W-1:0] v;
      for (int i = 0; i < N; i++) v[i*OUT_W +: OUT_W] = m_out[i];
      return v;
   endfunction

   // Advance one clock: compute the model's next state from the current
   // inputs, let the edge happen, then commit and leave 1 time unit of margin.
   task automatic tick();
      logic [OUT_W-1:0] n_out [N];
      logic [KEY_W-1:0] n_edge, n_mask, clr, press, k_smp;
      logic [IN_W-1:0]  s_smp;
      logic [31:0]      n_rdata;
      logic             n_hit, n_irq, inr, rst;
      int               off;
      rst   = reset;
      k_smp = key_in;
      s_smp = sw_in;
      for (int i = 0; i < N; i++) n_out[i] = m_out[i];
      n_edge = m_edge; n_mask = m_mask; n_rdata = '0; n_hit = 1'b0; n_irq = 1'b0;
      if (!rst) begin
         inr   = (bus.realaddr >= BASE) && (bus.realaddr < BASE + N + 4);
         off   = inr ? int'(bus.realaddr - BASE) : -1;
         clr   = '0;
         if (inr && bus.W) begin
            if (off < N) n_out[off] = bus.dout[OUT_W-1:0];
            else if (off == N + 2) clr = bus.dout[KEY_W-1:0];
            else if (off == N + 3) n_mask = bus.dout[KEY_W-1:0];
         end
         // pressed now (history S-1) but released one sample earlier (history S)
         press   = ~klog[S-1] & klog[S];
         n_edge  = (m_edge & ~clr) | press;
         n_hit   = inr;
         n_rdata = inr ? model_read(off) : 32'h0;
         n_irq   = |(m_edge & m_mask);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < N; i++) m_out[i] = '0;
         m_edge = '0; m_mask = '0; m_irq = 1'b0; m_hit = 1'b0; m_rdata = '0;
         for (int i = 0; i <= S; i++) begin
            klog[i] = '1;
            slog[i] = '0;
         end
      end else begin
         for (int i = 0; i < N; i++) m_out[i] = n_out[i];
         m_edge = n_edge; m_mask = n_mask; m_irq = n_irq; m_hit = n_hit; m_rdata = n_rdata;
         for (int i = S; i > 0; i--) begin
            klog[i] = klog[i-1];
            slog[i] = slog[i-1];
         end
         klog[0] = k_smp;
         slog[0] = s_smp;
      end
   endtask

   task automatic bus_set(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.W = w; bus.realaddr = a; bus.dout = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; key_in = 4'b0000; sw_in = '0;
      bus_set(1'b0, A_EDGE, 32'h0);
      tick(); tick();
      n_tests++; if (out_q !== '0) begin n_fail++; $display("[TB] FAIL reset_out_q got %h want 0", out_q); end
      n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h want 0", bus.rdata); end
      n_tests++; if (bus.hit !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_hit got %b want 0", bus.hit); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
      n_tests++; if (out_q1 !== '0) begin n_fail++; $display("[TB] FAIL reset_out_q1 got %h want 0", out_q1); end
      reset = 1'b0; key_in = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_tests++;
         if (bus.rdata !== 32'h0 || bus.hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_edge_quiet cycle %0d got hit=%b rdata=%h want hit=1 rdata=0", c, bus.hit, bus.rdata);
         end
      end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq_after got %b want 0", irq); end
   endtask

   task automatic test_led();
      bus1.W = 1'b1; bus1.realaddr = 32'd15; bus1.dout = 32'hFFFF_F2A5;
      tick();
      bus1.W = 1'b0;
      n_tests++; if (out_q1 !== 10'h2A5) begin n_fail++; $display("[TB] FAIL led_write got %h want 2a5", out_q1); end
      bus1.W = 1'b1; bus1.realaddr = 32'd14; bus1.dout = 32'h0;
      tick();
      n_tests++; if (out_q1 !== 10'h2A5) begin n_fail++; $display("[TB] FAIL led_addr14 got %h want 2a5", out_q1); end
      bus1.realaddr = 32'd20;
      tick();
      bus1.W = 1'b0;
      n_tests++; if (out_q1 !== 10'h2A5) begin n_fail++; $display("[TB] FAIL led_addr20 got %h want 2a5", out_q1); end
   endtask

   task automatic test_readback();
      bus_set(1'b1, BASE + 1, 32'h0000_0155);
      tick();
      bus_set(1'b0, BASE + 1, 32'h0);
      tick();
      n_tests++;
      if (bus.hit !== 1'b1 || bus.rdata !== 32'h155) begin
         n_fail++; $display("[TB] FAIL readback got hit=%b rdata=%h want hit=1 rdata=155", bus.hit, bus.rdata);
      end
      n_tests++; if (out_q !== model_out_q()) begin n_fail++; $display("[TB] FAIL readback_out_q got %h want %h", out_q, model_out_q()); end
      bus_set(1'b0, 32'h0, 32'h0);
      tick();
      n_tests++;
      if (bus.hit !== 1'b0 || bus.rdata !== 32'h0) begin
         n_fail++; $display("[TB] FAIL read_addr0 got hit=%b rdata=%h want hit=0 rdata=0", bus.hit, bus.rdata);
      end
      // same-cycle read returns old value, next read returns new value
      bus_set(1'b1, BASE, 32'h0000_0111); tick();
      bus_set(1'b1, BASE, 32'hFFFF_FE22); tick();
      n_tests++; if (bus.rdata !== 32'h111) begin n_fail++; $display("[TB] FAIL same_cycle_read got %h want 111", bus.rdata); end
      bus_set(1'b0, BASE, 32'h0); tick();
      n_tests++; if (bus.rdata !== 32'h222) begin n_fail++; $display("[TB] FAIL raw_read got %h want 222", bus.rdata); end
      bus_set(1'b0, A_MASK, 32'h0); tick();
      n_tests++; if (bus.hit !== 1'b1) begin n_fail++; $display("[TB] FAIL top_of_span_hit got %b want 1", bus.hit); end
      bus_set(1'b1, BASE + N + 4, 32'hFFFF_FFFF); tick();
      n_tests++; if (bus.hit !== 1'b0 || bus.rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL past_span got hit=%b rdata=%h want 0/0", bus.hit, bus.rdata); end
      bus_set(1'b1, A_SW, 32'hFFFF_FFFF); tick();
      bus_set(1'b0, A_SW, 32'h0); tick();
      n_tests++; if (bus.rdata !== m_rdata) begin n_fail++; $display("[TB] FAIL sw_ro got %h want %h", bus.rdata, m_rdata); end
      n_tests++; if (out_q !== model_out_q()) begin n_fail++; $display("[TB] FAIL out_q_after_ro got %h want %h", out_q, model_out_q()); end
   endtask

   task automatic test_switch();
      sw_in = '0;
      bus_set(1'b0, A_SW, 32'h0);
      for (int c = 0; c < 4; c++) tick();
      sw_in = 10'h3FF;
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_tests++;
         if (bus.rdata !== ((k >= S + 1) ? 32'h3FF : 32'h0) || bus.rdata !== m_rdata) begin
            n_fail++; $display("[TB] FAIL switch_sync tick %0d got %h want %h", k, bus.rdata, m_rdata);
         end
      end
   endtask

   task automatic test_key_irq();
      bus_set(1'b1, A_MASK, 32'h0000_0002); tick();
      bus_set(1'b0, A_EDGE, 32'h0);
      key_in = 4'b1101;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_tests++;
         if (irq !== ((k >= S + 2) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("[TB] FAIL key_irq tick %0d got %b want %b", k, irq, (k >= S + 2));
         end
      end
      n_tests++; if (m_edge !== 4'b0010 || bus.rdata !== 32'h2) begin n_fail++; $display("[TB] FAIL key_edge got %h want 2", bus.rdata); end
      bus_set(1'b1, A_EDGE, 32'h0000_0002); tick();
      bus_set(1'b0, A_KEY, 32'h0);
      n_tests++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL w1c_irq_plus1 got %b want 1", irq); end
      tick();
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL w1c_irq_plus2 got %b want 0", irq); end
      n_tests++; if (bus.rdata !== 32'h2) begin n_fail++; $display("[TB] FAIL key_level got %h want 2", bus.rdata); end
      key_in = 4'b1111;
      for (int c = 0; c < 5; c++) tick();
      n_tests++; if (irq !== 1'b0 || m_edge !== 4'b0000) begin n_fail++; $display("[TB] FAIL release_no_set got irq=%b want 0", irq); end
   endtask

   task automatic test_collision();
      bus_set(1'b0, A_EDGE, 32'h0);
      key_in = 4'b1110;
      tick(); tick();
      bus_set(1'b1, A_EDGE, 32'h0000_0001);
      tick();
      bus_set(1'b0, A_EDGE, 32'h0);
      tick();
      n_tests++; if (bus.rdata !== 32'h1) begin n_fail++; $display("[TB] FAIL collision got %h want 1", bus.rdata); end
      bus_set(1'b1, A_EDGE, 32'h0000_0001); tick();
      bus_set(1'b0, A_EDGE, 32'h0);
      for (int c = 0; c < 8; c++) begin
         tick();
         n_tests++;
         if (bus.rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL held_key cycle %0d got %h want 0", c, bus.rdata); end
      end
      key_in = 4'b1111;
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         bus_set($urandom_range(0, 1) == 1, BASE - 2 + 32'($urandom_range(0, N + 7)), $urandom());
         if ($urandom_range(0, 7) == 0) sw_in = IN_W'($urandom());
         for (int b = 0; b < KEY_W; b++)
            if ($urandom_range(0, 5) == 0) key_in[b] = ~key_in[b];
         tick();
         n_tests++;
         if (bus.rdata !== m_rdata || bus.hit !== m_hit || irq !== m_irq || out_q !== model_out_q()) begin
            n_fail++;
            $display("[TB] FAIL random cycle %0d got rdata=%h hit=%b irq=%b out=%h want rdata=%h hit=%b irq=%b out=%h",
                     c, bus.rdata, bus.hit, irq, out_q, m_rdata, m_hit, m_irq, model_out_q());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      bus_set(1'b0, 32'h0, 32'h0);
      bus1.W = 1'b0; bus1.realaddr = 32'h0; bus1.dout = 32'h0;
      test_reset();
      test_led();
      test_readback();
      test_switch();
      test_key_irq();
      test_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
